// File: rtl/dmem_arbiter.sv
// dmem_arbiter: core/UART arbiter and sequencer for the single-port data memory.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; otherwise the core has fixed priority.
module dmem_arbiter #(
    parameter int WIDTH    = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             c_req,
    input  logic             c_we,
    input  logic [WIDTH-1:0] c_addr,
    input  logic [WIDTH-1:0] c_wdata,
    input  logic [2:0]       c_func3,
    output logic             c_gnt,
    output logic             c_rvalid,
    output logic [WIDTH-1:0] c_rdata,
    input  logic             u_req,
    input  logic             u_we,
    input  logic [WIDTH-1:0] u_addr,
    input  logic [WIDTH-1:0] u_wdata,
    input  logic [2:0]       u_func3,
    input  logic             u_lock,
    output logic             u_gnt,
    output logic             u_rvalid,
    output logic [WIDTH-1:0] u_rdata,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_rd_en,
    output logic             mem_wr_en,
    output logic [2:0]       mem_func3,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [1:0]       owner
);
    typedef enum logic [1:0] {IDLE = 2'b00, CORE = 2'b01, UART = 2'b10, ULOCK = 2'b11} state_e;
    localparam int CW  = $clog2(MAX_LOCK + 1);
    localparam int LIM = MAX_LOCK - 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    lock_cnt_q, lock_cnt_d;
    logic             force_q, force_d;
    logic             c_rvalid_q, u_rvalid_q;
    logic [WIDTH-1:0] c_rdata_q, u_rdata_q;
    logic             u_first, c_win, u_win, lim_hit;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_u_q;
    assign u_first = ~last_u_q;
    always_ff @(posedge clk)
        if (rst) last_u_q <= 1'b1;
        else if (c_gnt || u_gnt) last_u_q <= u_gnt;
`else
    assign u_first = 1'b0;
`endif

    // after a forced lock release the core is served first whatever the priority mode
    assign c_win = (state_q != ULOCK) & c_req & (force_q | ~u_req | ~u_first);
    assign u_win = u_req & ((state_q == ULOCK) | ~c_req | (~force_q & u_first));
    assign c_gnt = c_win & ~rst;
    assign u_gnt = u_win & ~rst;

    assign mem_addr  = c_gnt ? c_addr  : u_gnt ? u_addr  : '0;
    assign mem_wdata = c_gnt ? c_wdata : u_gnt ? u_wdata : '0;
    assign mem_func3 = c_gnt ? c_func3 : u_gnt ? u_func3 : 3'b000;
    assign mem_rd_en = (c_gnt & ~c_we) | (u_gnt & ~u_we);
    assign mem_wr_en = (c_gnt & c_we) | (u_gnt & u_we);

    always_comb begin
        lim_hit = int'(lock_cnt_q) + 1 >= LIM;
        if (state_q == ULOCK) begin
            state_d    = (!u_lock || (u_gnt && lim_hit)) ? IDLE : ULOCK;
            lock_cnt_d = u_gnt ? lock_cnt_q + CW'(1) : lock_cnt_q;
            force_d    = u_gnt && lim_hit;
        end else begin
            state_d    = c_gnt ? CORE : u_gnt ? (u_lock ? ULOCK : UART) : IDLE;
            lock_cnt_d = '0;
            force_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
            force_q    <= 1'b0;
            c_rvalid_q <= 1'b0;
            u_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            u_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            force_q    <= force_d;
            c_rvalid_q <= c_gnt & ~c_we;
            u_rvalid_q <= u_gnt & ~u_we;
            if (c_gnt && !c_we) c_rdata_q <= mem_rdata;
            if (u_gnt && !u_we) u_rdata_q <= mem_rdata;
        end
    end

    // a reset arriving right after a load grant kills the pending rvalid in that same cycle
    assign c_rvalid = c_rvalid_q & ~rst;
    assign u_rvalid = u_rvalid_q & ~rst;
    assign c_rdata  = c_rdata_q;
    assign u_rdata  = u_rdata_q;
    assign owner    = rst ? 2'b00 : state_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of grants, read return, lock/forced release and reset.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, u_req, u_we, u_lock;
    logic [31:0] c_addr, c_wdata, u_addr, u_wdata;
    logic [2:0]  c_func3, u_func3;
    logic        c_gnt, c_rvalid, u_gnt, u_rvalid;
    logic [31:0] c_rdata, u_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_rd_en, mem_wr_en;
    logic [2:0]  mem_func3;
    logic [1:0]  owner;
    logic [31:0] mem [64];
    int          total = 0;
    int          bad = 0;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    dmem_arbiter #(.WIDTH(32), .MAX_LOCK(4)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_func3(c_func3),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .u_req(u_req), .u_we(u_we), .u_addr(u_addr), .u_wdata(u_wdata), .u_func3(u_func3),
        .u_lock(u_lock), .u_gnt(u_gnt), .u_rvalid(u_rvalid), .u_rdata(u_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_func3(mem_func3), .mem_rdata(mem_rdata), .owner(owner)
    );

    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr[7:2]];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4] = 32'hDEADBEEF;
        mem[5] = 32'h12345678;
        rst = 1'b1; c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; c_wdata = 32'h0; c_func3 = 3'd2;
        u_req = 1'b0; u_we = 1'b0; u_addr = 32'h14; u_wdata = 32'h0; u_func3 = 3'd2; u_lock = 1'b0;
        nxt;
        smp;
        chk("rst_cgnt", c_gnt, 0);
        chk("rst_owner", owner, 0);
        chk("rst_rdata", c_rdata, 0);
        nxt;
        rst = 1'b0;
        smp;
        chk("ld_cgnt", c_gnt, 1);
        chk("ld_rden", mem_rd_en, 1);
        chk("ld_wren", mem_wr_en, 0);
        chk("ld_addr", mem_addr, 32'h10);
        chk("ld_func3", mem_func3, 2);
        chk("ld_owner0", owner, 0);
        nxt;
        c_req = 1'b0;
        smp;
        chk("ld_rvalid", c_rvalid, 1);
        chk("ld_rdata", c_rdata, 32'hDEADBEEF);
        chk("ld_owner1", owner, 1);
        nxt;
        smp;
        chk("ld_owner2", owner, 0);
        chk("ld_rvalid_off", c_rvalid, 0);
        chk("ld_rdata_hold", c_rdata, 32'hDEADBEEF);
        rst = 1'b1;
        nxt;
        rst = 1'b0; c_req = 1'b1; u_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            smp;
            chk("cont_cgnt", c_gnt, RR ? ((i % 2) == 0) : 1'b1);
            chk("cont_ugnt", u_gnt, RR ? ((i % 2) == 1) : 1'b0);
            if (i > 0) chk("cont_crv", c_rvalid, RR ? ((i % 2) == 1) : 1'b1);
            nxt;
        end
        chk("cont_urdata", u_rdata, RR ? 32'h12345678 : 32'h0);
        c_req = 1'b0; u_req = 1'b0;
        nxt;
        u_req = 1'b1; u_we = 1'b1; u_addr = 32'h20; u_wdata = 32'h55; u_func3 = 3'd0; u_lock = 1'b1;
        smp;
        chk("st_ugnt", u_gnt, 1);
        chk("st_wren", mem_wr_en, 1);
        chk("st_wdata", mem_wdata, 32'h55);
        chk("st_addr", mem_addr, 32'h20);
        chk("st_func3", mem_func3, 0);
        chk("st_owner", owner, 0);
        nxt;
        c_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            smp;
            chk("lk_ugnt", u_gnt, 1);
            chk("lk_cgnt", c_gnt, 0);
            chk("lk_owner", owner, 3);
            chk("lk_urv", u_rvalid, 0);
            nxt;
        end
        u_lock = 1'b0;
        smp;
        chk("ul_ugnt", u_gnt, 1);
        chk("ul_cgnt", c_gnt, 0);
        nxt;
        u_req = 1'b0;
        smp;
        chk("rel_cgnt", c_gnt, 1);
        chk("rel_owner", owner, 0);
        nxt;
        c_req = 1'b0; u_req = 1'b1; u_we = 1'b0; u_addr = 32'h14; u_func3 = 3'd2; u_lock = 1'b1;
        smp;
        chk("ml_ugnt0", u_gnt, 1);
        nxt;
        c_req = 1'b1;
        for (int i = 1; i < 4; i++) begin
            smp;
            chk("ml_ugnt", u_gnt, 1);
            chk("ml_cgnt", c_gnt, 0);
            chk("ml_owner", owner, 3);
            nxt;
        end
        chk("ml_urdata", u_rdata, 32'h12345678);
        smp;
        chk("force_cgnt", c_gnt, 1);
        chk("force_ugnt", u_gnt, 0);
        chk("force_owner", owner, 0);
        chk("force_urv", u_rvalid, 1);
        nxt;
        c_req = 1'b0;
        smp;
        chk("relock_ugnt", u_gnt, 1);
        chk("relock_crv", c_rvalid, 1);
        nxt;
        smp;
        chk("relock_owner", owner, 3);
        nxt;
        u_req = 1'b0; u_lock = 1'b0;
        nxt;
        smp;
        chk("idle_mem", |{mem_addr, mem_wdata, mem_rd_en, mem_wr_en, mem_func3}, 0);
        chk("idle_gnt", {c_gnt, u_gnt}, 0);
        chk("idle_owner", owner, 0);
        nxt;
        u_req = 1'b1;
        smp;
        chk("rl_ugnt", u_gnt, 1);
        nxt;
        rst = 1'b1;
        smp;
        chk("rl_urv", u_rvalid, 0);
        chk("rl_owner", owner, 0);
        chk("rl_gnt", {c_gnt, u_gnt}, 0);
        chk("rl_rden", mem_rd_en, 0);
        nxt;
        rst = 1'b0; u_req = 1'b0;
        smp;
        chk("rl_urv2", u_rvalid, 0);
        chk("rl_owner2", owner, 0);
        chk("rl_urdata", u_rdata, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-port data memory. Shares the memory between the core load/store port (C) and the UART loader/debug port (U). Selects one requester per cycle, drives the memory's address, data, read/write enables and func3, and returns registered read data to the winner. Sits between the core/UART front-ends and the data memory instance.

## Interface
- WIDTH, 32, data and address width
- MAX_LOCK, 16, maximum consecutive locked U grants before a forced release
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- c_req  in  1  core request; held until c_gnt
- c_we  in  1  1 = store, 0 = load
- c_addr  in  WIDTH  byte address
- c_wdata  in  WIDTH  store data
- c_func3  in  3  load/store size code, passed through unchanged
- c_gnt  out  1  core access issued this cycle
- c_rvalid  out  1  core load data valid, one-cycle pulse
- c_rdata  out  WIDTH  core load data
- u_req, u_we, u_addr, u_wdata, u_func3  in  1/1/WIDTH/WIDTH/3  UART port; same meaning as the C port
- u_lock  in  1  U requests exclusive ownership across consecutive accesses
- u_gnt, u_rvalid  out  1  UART grant / load-data valid
- u_rdata  out  WIDTH  UART load data
- mem_addr, mem_wdata  out  WIDTH  to memory
- mem_rd_en, mem_wr_en  out  1  to memory
- mem_func3  out  3  to memory
- mem_rdata  in  WIDTH  combinational read data from memory
- owner  out  2  00 idle, 01 core, 10 UART, 11 UART locked

## Operation
- States: IDLE, CORE, UART, ULOCK. `owner` encodes the state of the current cycle.
- Grant decision is combinational from the request inputs and the registered state. At most one of c_gnt/u_gnt is high per cycle.
- The granted port's addr/wdata/func3 are muxed onto mem_*:
  - mem_rd_en = gnt & ~we
  - mem_wr_en = gnt & we
- With no grant, all mem_* outputs are 0.
- Read return: on a granted load, mem_rdata is captured at posedge into the winner's rdata register, and the winner's rvalid is high for exactly the next cycle. rdata holds its value until the next load to that port.
- Stores produce no rvalid. The memory commits the write on the negedge of the grant cycle.
- Contention resolution (both requesting, no lock): see Configuration.
- Lock:
  - A granted U access with u_lock=1 enters ULOCK and clears lock_cnt.
  - In ULOCK only U is granted; lock_cnt increments per U grant.
  - ULOCK exits to IDLE when u_lock=0, or when lock_cnt reaches MAX_LOCK-1.
  - After a forced exit, the next cycle grants C if c_req=1 (starvation guard), regardless of priority mode.
  - u_lock is ignored unless it accompanies a U grant.
- State transitions:
  - IDLE→CORE/UART on grant.
  - CORE/UART→IDLE when no request.
  - CORE↔UART per arbitration.
- A request dropped before grant is a protocol violation; behaviour is undefined and not checked.

## Timing
- Grant latency: 0 cycles when uncontested (gnt in the same cycle as req).
- Load data latency: rvalid exactly 1 cycle after gnt.
- Throughput: one access per cycle. Back-to-back grants to the same port are allowed.
- Reset (posedge with rst=1):
  - state=IDLE, lock_cnt=0, owner=00
  - c_rvalid=u_rvalid=0, c_rdata=u_rdata=0
  - Round-robin pointer = "U last", so C wins the first contention.
  - Grants are forced to 0 during the rst cycle.
- Reset mid-lock or mid-load: the pending rvalid is suppressed and the lock is dropped.
- Simultaneous grant and new request on the other port: the other port waits at least one cycle.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - On contention, grant the port not granted most recently.
  - The pointer updates on every grant.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority, C always beats U on contention.
  - The pointer logic is absent.
  - The lock and forced-release rules are unchanged.

## Test plan
- Reset, then c_req load at addr 0x10, memory word 0xDEADBEEF → c_gnt same cycle, mem_rd_en=1, mem_addr=0x10; next cycle c_rvalid=1, c_rdata=0xDEADBEEF; owner=01 then 00.
- Both ports request continuously for 4 cycles:
  - With ARB_ROUND_ROBIN_EN → grants C,U,C,U.
  - Without it → C,C,C,C, with u_gnt=0.
- U store 0x55 to 0x20, func3=SB, u_lock=1, with c_req held → owner=11, C blocked. Drop u_lock after 3 U grants → C granted the next cycle.
- MAX_LOCK=4, u_lock and u_req held, c_req held → exactly 4 U grants, then one C grant, then U may relock.
- rst asserted the cycle after a U load grant → u_rvalid stays 0, owner=00, no grant in the rst cycle.
- Idle cycle with no requests → all mem_* = 0 and both gnt = 0.
